// File: rtl/instruction_fetch.sv
// LR35902 fetch stage: reads opcode, optional CB prefix and immediate bytes at the PC,
// then presents one assembled instruction to decode over a valid/ready handshake.
module instruction_fetch #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CB_OPCODE  = 8'hCB
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   pcIn,
    output logic                    pcCountEnable,
    input  logic                    flush,
    output logic [ADDR_WIDTH-1:0]   memAddr,
    output logic                    memRead,
    input  logic                    memReady,
    input  logic [DATA_WIDTH-1:0]   memDataIn,
    output logic                    instrValid,
    input  logic                    instrReady,
    output logic [DATA_WIDTH-1:0]   instrOpcode,
    output logic                    instrPrefixed,
    output logic [2*DATA_WIDTH-1:0] instrImm,
    output logic [1:0]              instrLength,
    output logic [ADDR_WIDTH-1:0]   instrPc,
    output logic                    instrIllegal
);

    typedef enum logic [2:0] {
        S_OPCODE,
        S_PREFIX,
        S_IMM_LO,
        S_IMM_HI,
        S_HOLD
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_take;
    logic [DATA_WIDTH-1:0]   r_opcode;
    logic                    r_prefixed;
    logic [2*DATA_WIDTH-1:0] r_imm;
    logic [1:0]              r_len;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic                    r_illegal;

    // Total bytes of an unprefixed instruction; the CB prefix itself counts as a 2-byte op.
    function automatic logic [1:0] op_len(input logic [DATA_WIDTH-1:0] op);
        logic [1:0] len;
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
            8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
                len = 2'd3;
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8, CB_OPCODE:
                len = 2'd2;
            default:
                len = 2'd1;
        endcase
        return len;
    endfunction

    function automatic logic op_illegal(input logic [DATA_WIDTH-1:0] op);
        logic ill;
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: ill = 1'b1;
            default:                            ill = 1'b0;
        endcase
        return ill;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_OPCODE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        memRead       = 1'b0;
        memAddr       = '0;
        pcCountEnable = 1'b0;
        w_take        = 1'b0;
        instrValid    = (r_state == S_HOLD);

        // Reset and flush both silence the memory side in the cycle they are asserted.
        if (r_state != S_HOLD && !flush && !reset) begin
            memRead       = 1'b1;
            memAddr       = pcIn;
            w_take        = memReady;
            pcCountEnable = memReady;
        end

        if (flush) begin
            w_next = S_OPCODE;
        end else begin
            case (r_state)
                S_OPCODE: begin
                    if (memReady) begin
                        if (memDataIn == CB_OPCODE) begin
                            w_next = S_PREFIX;
                        end else if (op_len(memDataIn) != 2'd1) begin
                            w_next = S_IMM_LO;
                        end else begin
                            w_next = S_HOLD;
                        end
                    end
                end
                S_PREFIX: begin
                    if (memReady) w_next = S_HOLD;
                end
                S_IMM_LO: begin
                    if (memReady) w_next = (r_len == 2'd3) ? S_IMM_HI : S_HOLD;
                end
                S_IMM_HI: begin
                    if (memReady) w_next = S_HOLD;
                end
                S_HOLD: begin
                    if (instrReady) w_next = S_OPCODE;
                end
                default: w_next = S_OPCODE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode   <= '0;
            r_prefixed <= 1'b0;
            r_imm      <= '0;
            r_len      <= '0;
            r_pc       <= '0;
            r_illegal  <= 1'b0;
        end else if (w_take) begin
            case (r_state)
                S_OPCODE: begin
                    r_opcode   <= memDataIn;
                    r_prefixed <= 1'b0;
                    r_imm      <= '0;
                    r_len      <= op_len(memDataIn);
                    r_pc       <= pcIn;
                    r_illegal  <= op_illegal(memDataIn);
                end
                S_PREFIX: begin
                    r_opcode   <= memDataIn;
                    r_prefixed <= 1'b1;
                end
                S_IMM_LO: r_imm[DATA_WIDTH-1:0]            <= memDataIn;
                S_IMM_HI: r_imm[2*DATA_WIDTH-1:DATA_WIDTH] <= memDataIn;
                default: ;
            endcase
        end
    end

    always_comb begin
        instrOpcode   = r_opcode;
        instrPrefixed = r_prefixed;
        instrImm      = r_imm;
        instrLength   = r_len;
        instrPc       = r_pc;
        instrIllegal  = r_illegal;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed cases, then random programs fetched
// from a byte-array memory under random memReady/instrReady/flush.
module tb_instruction_fetch;

    typedef struct packed {
        logic [7:0]  op;
        logic        pref;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        memReady = 1'b0;
    logic        instrReady = 1'b0;
    logic [15:0] pcIn;
    logic        pcCountEnable;
    logic [15:0] memAddr;
    logic        memRead;
    logic [7:0]  memDataIn;
    logic        instrValid;
    logic [7:0]  instrOpcode;
    logic        instrPrefixed;
    logic [15:0] instrImm;
    logic [1:0]  instrLength;
    logic [15:0] instrPc;
    logic        instrIllegal;

    logic [15:0] pc_q = 16'h0000;
    logic [15:0] pc_val = 16'h0100;
    logic        pc_load = 1'b1;
    logic [7:0]  mem [0:65535];
    logic [7:0]  picks [8] = '{8'hC3, 8'h01, 8'h3E, 8'hE0, 8'hD3, 8'hFD, 8'hCD, 8'h18};
    exp_t        exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [43:0] fields;
    logic [62:0] outs_all;

    instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .CB_OPCODE(8'hCB)) dut (
        .clk(clk), .reset(reset), .pcIn(pcIn), .pcCountEnable(pcCountEnable),
        .flush(flush), .memAddr(memAddr), .memRead(memRead), .memReady(memReady),
        .memDataIn(memDataIn), .instrValid(instrValid), .instrReady(instrReady),
        .instrOpcode(instrOpcode), .instrPrefixed(instrPrefixed), .instrImm(instrImm),
        .instrLength(instrLength), .instrPc(instrPc), .instrIllegal(instrIllegal)
    );

    always #5 clk = ~clk;

    assign pcIn      = pc_q;
    assign memDataIn = mem[memAddr];
    assign fields    = {instrOpcode, instrPrefixed, instrImm, instrLength, instrPc, instrIllegal};
    assign outs_all  = {pcCountEnable, memAddr, memRead, instrValid, fields};

    // Program counter: loadable, incremented by the fetch stage's count pulse.
    always @(posedge clk) begin
        if (pc_load)            pc_q <= pc_val;
        else if (pcCountEnable) pc_q <= pc_q + 16'd1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode tables.
    function automatic exp_t model(input logic [15:0] pc, input logic [7:0] b0, b1, b2);
        exp_t e;
        e.pc = pc; e.pref = 1'b0; e.ill = 1'b0; e.imm = 16'h0000; e.op = b0; e.len = 2'd1;
        if (b0 == 8'hCB) begin
            e.pref = 1'b1; e.op = b1; e.len = 2'd2;
        end else begin
            e.ill = b0 inside {8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED,
                               8'hF4, 8'hFC, 8'hFD};
            if (b0 inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
                           8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA}) begin
                e.len = 2'd3; e.imm = {b2, b1};
            end else if (b0 inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                    8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
                                    8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0,
                                    8'hE8, 8'hF8}) begin
                e.len = 2'd2; e.imm = {8'h00, b1};
            end
        end
        return e;
    endfunction

    task automatic flush_to(input logic [15:0] addr);
        @(negedge clk);
        flush = 1'b1; pc_load = 1'b1; pc_val = addr; memReady = 1'b1;
        exp_q.delete();
        #1 check("flush_gate", {pcCountEnable, memRead}, 2'b00);
    endtask

    task automatic flush_end();
        @(negedge clk);
        flush = 1'b0; pc_load = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] addr, input logic [7:0] b0, b1, b2,
                             input bit do_flush, input int stall_at, input int stall_n,
                             input int hold_n);
        exp_t        e;
        logic [15:0] a;
        if (do_flush) flush_to(addr);
        e = model(addr, b0, b1, b2);
        mem[addr] = b0; mem[addr + 16'd1] = b1; mem[addr + 16'd2] = b2;
        exp_q.push_back(e);
        if (do_flush) flush_end();
        instrReady = 1'b0;
        for (int i = 0; i < int'(e.len); i++) begin
            a = addr + 16'(i);
            for (int s = 0; s < ((i == stall_at) ? stall_n : 0); s++) begin
                memReady = 1'b0;
                #1 check("stall_count", pcCountEnable, 0);
                check("stall_read", {memRead, memAddr}, {1'b1, a});
                @(negedge clk);
            end
            memReady = 1'b1;
            #1 check("byte_count", {pcCountEnable, memRead, memAddr}, {2'b11, a});
            check("early_valid", instrValid, 0);
            @(negedge clk);
        end
        memReady = 1'b0;
        for (int h = 0; h < hold_n; h++) begin
            #1 check("hold_ctl", {instrValid, memRead, pcCountEnable}, 3'b100);
            check("hold_fields", fields, e);
            @(negedge clk);
        end
        instrReady = 1'b1;
        #1 check("hold_ctl", {instrValid, memRead, pcCountEnable}, 3'b100);
        @(negedge clk);
        instrReady = 1'b0;
        #1 check("accept_drop", {instrValid, memRead, memAddr}, {2'b01, addr + 16'(e.len)});
    endtask

    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (!reset) begin
            if (memRead) check("mem_addr", memAddr, pcIn);
            if (pcCountEnable) check("count_needs_req", {memRead, memReady, flush}, 3'b110);
            if (instrValid && instrReady && !flush) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_instr: got %h, expected none", fields);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", fields, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t        e;
        logic [15:0] a0, a;
        logic [7:0]  bb [3];
        int          n, budget;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1 check("reset_outs", outs_all, 0);
        reset = 1'b0; pc_load = 1'b0;

        run_instr(16'h0100, 8'h00, 8'h00, 8'h00, 1'b0, -1, 0, 0);
        run_instr(16'h0150, 8'hC3, 8'h34, 8'h12, 1'b1, -1, 0, 0);
        run_instr(16'h0200, 8'hCB, 8'h7C, 8'h00, 1'b1, -1, 0, 0);
        run_instr(16'h0300, 8'hD3, 8'h00, 8'h00, 1'b1, -1, 0, 0);
        run_instr(16'h0350, 8'h3E, 8'h55, 8'h00, 1'b1, 1, 2, 0);
        run_instr(16'hFFFF, 8'h21, 8'h11, 8'h22, 1'b1, -1, 0, 2);

        // Flush during IMM_LO, then flush while holding with instrReady high.
        flush_to(16'h0400);
        mem[16'h0400] = 8'h3E; mem[16'h0401] = 8'h99;
        flush_end();
        memReady = 1'b1; instrReady = 1'b0;
        #1 check("imm_flush_op", pcCountEnable, 1);
        @(negedge clk);
        flush = 1'b1; pc_load = 1'b1; pc_val = 16'h0500; exp_q.delete();
        mem[16'h0500] = 8'h00;
        #1 check("imm_flush_gate", {pcCountEnable, memRead}, 2'b00);
        @(negedge clk);
        flush = 1'b0; pc_load = 1'b0;
        exp_q.push_back(model(16'h0500, 8'h00, 8'h00, 8'h00));
        #1 check("refetch_new_pc", {memRead, memAddr, pcCountEnable, instrValid},
                 {1'b1, 16'h0500, 2'b10});
        @(negedge clk);
        flush = 1'b1; pc_load = 1'b1; pc_val = 16'h0600; memReady = 1'b0; instrReady = 1'b1;
        exp_q.delete();
        #1 check("hold_before_flush", instrValid, 1);
        @(negedge clk);
        flush = 1'b0; pc_load = 1'b0; instrReady = 1'b0;
        #1 check("hold_flushed", {instrValid, memRead, memAddr}, {2'b01, 16'h0600});

        // Reset arriving in IMM_HI.
        flush_to(16'h0700);
        mem[16'h0700] = 8'h01; mem[16'h0701] = 8'hAA; mem[16'h0702] = 8'hBB;
        flush_end();
        memReady = 1'b1; instrReady = 1'b0;
        #1 check("rst_seq_op", pcCountEnable, 1);
        @(negedge clk);
        #1 check("rst_seq_lo", pcCountEnable, 1);
        @(negedge clk);
        reset = 1'b1; pc_load = 1'b1; pc_val = 16'h0800;
        #1 check("rst_mid_gate", {pcCountEnable, memRead}, 2'b00);
        @(negedge clk);
        #1 check("rst_mid_outs", outs_all, 0);
        reset = 1'b0; pc_load = 1'b0;
        run_instr(16'h0800, 8'h06, 8'h42, 8'h00, 1'b0, -1, 0, 4);

        for (int seg = 0; seg < 40; seg++) begin
            a0 = (seg % 5 == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            flush_to(a0);
            memReady = ($urandom_range(0, 1) != 0);
            a = a0;
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 3))
                    0:       bb[0] = 8'hCB;
                    1:       bb[0] = picks[$urandom_range(0, 7)];
                    default: bb[0] = 8'($urandom);
                endcase
                bb[1] = 8'($urandom);
                bb[2] = 8'($urandom);
                e = model(a, bb[0], bb[1], bb[2]);
                for (int j = 0; j < int'(e.len); j++) mem[a + 16'(j)] = bb[j];
                exp_q.push_back(e);
                a = a + 16'(e.len);
            end
            flush_end();
            budget = 0;
            while (exp_q.size() != 0 && budget < 400) begin
                memReady   = ($urandom_range(0, 3) != 0);
                instrReady = ($urandom_range(0, 2) != 0);
                if (seg % 7 == 3 && $urandom_range(0, 19) == 0) break;
                @(negedge clk);
                budget++;
            end
            check("seg_timeout", budget >= 400, 0);
        end

        @(negedge clk);
        memReady = 1'b0; instrReady = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
